seg_scan_driver: RTL
====================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100000, meaning clock cycles each digit is shown (minimum 2).
REQ-002 The block SHALL have parameter BLINK_DIV, default 50000000, meaning clock cycles per blink half-period (minimum 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have ports led0..led7, input, 4 bits each: the digit code for positions 0..7, with position 0 rightmost.
REQ-006 The block SHALL have port blink, input, 8 bits: bit i marks position i as blink-enabled.
REQ-007 The block SHALL have port dot, input, 8 bits: bit i requests the decimal point at position i.
REQ-008 The block SHALL have port is_blink, input, 1 bit: global blink enable from the editor.
REQ-009 The block SHALL have port an, output, 8 bits: digit select, active-low, one-hot-low while scanning.
REQ-010 The block SHALL have port seg, output, 8 bits: segments, active-low, with seg[7]=dp and seg[6:0]=g,f,e,d,c,b,a.

Function
REQ-011 The scan counter SHALL count 0..SCAN_DIV-1 and wrap; on the wrap cycle the digit index (3 bits) SHALL increment modulo 8 (7 -> 0).
REQ-012 The an and seg outputs SHALL be registered; in cycle t+1 they SHALL reflect the digit index and inputs sampled in cycle t (1-cycle latency, no input latching).
REQ-013 For digit index k, an SHALL be all ones except an[k]=0, and an and seg SHALL change in the same cycle.
REQ-014 The font SHALL be hex 0-F (a at bit 0, 0 = lit): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E; these values include dp off.
REQ-015 seg[7] SHALL be 0 when dot[k]=1 and the digit is not blanked, and 1 otherwise.
REQ-016 The blink counter SHALL count 0..BLINK_DIV-1; on wrap, blink_phase SHALL toggle (0 = visible, 1 = hidden).
REQ-017 Position k SHALL be blanked (seg=FF, an still selects k) when is_blink=1, blink[k]=1 and blink_phase=1.
REQ-018 On a rising edge of is_blink (registered previous value 0, current 1), the blink counter and blink_phase SHALL clear to 0 in that cycle, so blinking always starts visible; this rule takes priority over a wrap in the same cycle.
REQ-019 While is_blink=0, the blink counter SHALL free-run, but no position SHALL be blanked.
REQ-020 Input changes mid-slot SHALL appear on seg on the next cycle; no synchronisation beyond REQ-012 is provided.
REQ-021 The scan and blink counters SHALL be independent; a simultaneous scan wrap and blink toggle SHALL both take effect in the same cycle.

Reset
REQ-022 While rst_n=0 at a clock edge: an=FF, seg=FF, scan counter=0, digit index=0, blink counter=0, blink_phase=0, previous-is_blink register=0.
REQ-023 In the first cycle after rst_n rises, outputs SHALL show position 0 (an=FE, seg per led0, dot[0] and blink rules).
REQ-024 Reset asserted mid-scan SHALL override all counting in that cycle.

Structure
REQ-025 Package seg_pkg SHALL hold the 16-entry font constants, the dp bit position, the all-off value FF, and the default SCAN_DIV and BLINK_DIV values.
REQ-026 Combinational sub-module seg_hex_decode (4-bit code in, 7-bit active-low segments out) SHALL implement the font; the scan, blink, and output registers SHALL live in seg_scan_driver.

Verification (SCAN_DIV=4, BLINK_DIV=16)
REQ-027 Reset release with led0..led7=0..7, dot=0, is_blink=0 -> an steps FE, FD, ... 7F, FE every 4 cycles; seg sequence C0, F9, A4, B0, 99, 92, 82, F8.
REQ-028 led3=4'hB, dot=8'h08 -> during the an=F7 slot, seg=03 (83 with dp lit).
REQ-029 is_blink rises with blink=8'h03, led0=5 -> position 0 shows 92 for 16 cycles, then FF for 16 cycles, alternating; positions 2-7 are never blanked.
REQ-030 is_blink falls during the hidden phase -> next position-0 slot shows 92; re-raising is_blink restarts the visible phase with a full 16 cycles.
REQ-031 rst_n pulled low for 1 cycle mid-slot at index 5 -> next cycle an=FF, seg=FF; the cycle after release shows an=FE.
REQ-032 Change led2 mid-slot while an=FB -> seg updates exactly 1 cycle later, and an is unchanged.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared font table and constants for the 8-digit seven-segment scan driver
package seg_pkg;

    localparam int SCAN_DIV_DEF  = 100000;
    localparam int BLINK_DIV_DEF = 50000000;
    localparam int DP_BIT        = 7;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low g..a per hex code; entry 15 is listed first.
    localparam logic [15:0][6:0] FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - 4-bit hex code to active-low g..a segment pattern
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    assign seg_o = FONT[code_i];

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed 8-digit seven-segment driver with per-digit blink and dp
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_DEF,
    parameter int BLINK_DIV = BLINK_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] led0,
    input  logic [3:0] led1,
    input  logic [3:0] led2,
    input  logic [3:0] led3,
    input  logic [3:0] led4,
    input  logic [3:0] led5,
    input  logic [3:0] led6,
    input  logic [3:0] led7,
    input  logic [7:0] blink,
    input  logic [7:0] dot,
    input  logic       is_blink,
    output logic [7:0] an,
    output logic [7:0] seg
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]    digit_q, digit_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic          is_blink_prev_q;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;

    logic [3:0]    code;
    logic [6:0]    font_seg;
    logic          rise;
    logic          phase_eff;
    logic          blank;

    always_comb begin
        code = led0;
        case (digit_q)
            3'd1:    code = led1;
            3'd2:    code = led2;
            3'd3:    code = led3;
            3'd4:    code = led4;
            3'd5:    code = led5;
            3'd6:    code = led6;
            3'd7:    code = led7;
            default: code = led0;
        endcase
    end

    seg_hex_decode u_dec (
        .code_i (code),
        .seg_o  (font_seg)
    );

    // A fresh is_blink edge forces the visible phase even in the edge cycle itself.
    assign rise      = is_blink & ~is_blink_prev_q;
    assign phase_eff = rise ? 1'b0 : blink_phase_q;
    assign blank     = is_blink & blink[digit_q] & phase_eff;

    always_comb begin
        scan_cnt_d    = scan_cnt_q + 1'b1;
        digit_d       = digit_q;
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            digit_d    = digit_q + 3'd1;
        end
        if (rise) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
        an_d  = ~(8'b1 << digit_q);
        seg_d = blank ? SEG_OFF : {~dot[digit_q], font_seg};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_q      <= '0;
            digit_q         <= '0;
            blink_cnt_q     <= '0;
            blink_phase_q   <= 1'b0;
            is_blink_prev_q <= 1'b0;
            an_q            <= SEG_OFF;
            seg_q           <= SEG_OFF;
        end else begin
            scan_cnt_q      <= scan_cnt_d;
            digit_q         <= digit_d;
            blink_cnt_q     <= blink_cnt_d;
            blink_phase_q   <= blink_phase_d;
            is_blink_prev_q <= is_blink;
            an_q            <= an_d;
            seg_q           <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule
